// File: rtl/div_unit_pkg.sv
// Shared encodings for the radix-2 restoring divider: FSM states and handshake levels.
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;

    localparam logic DIV_START             = 1'b1;
    localparam logic DIV_STOP              = 1'b0;
    localparam logic DIV_RESULT_READY      = 1'b1;
    localparam logic DIV_RESULT_NOT_READY  = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring iteration: shift {rem,q} left, trial-subtract divisor, restore on borrow.
// Latency: combinational. Backpressure: none (pure function of inputs).
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] i_remq,
    input  logic [DATA_W-1:0]   i_divisor,
    output logic [2*DATA_W-1:0] o_remq
);

    logic [DATA_W:0]   w_hi;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-2:0] w_q_shift;

    // Upper DATA_W+1 bits of the shifted pair; the extra bit keeps the trial subtract exact.
    assign w_hi      = i_remq[2*DATA_W-1:DATA_W-1];
    assign w_q_shift = i_remq[DATA_W-2:0];
    assign w_diff    = w_hi - {1'b0, i_divisor};

    always_comb begin
        if (w_diff[DATA_W] == 1'b0) begin
            o_remq = {w_diff[DATA_W-1:0], w_q_shift, 1'b1};
        end else begin
            o_remq = {w_hi[DATA_W-1:0], w_q_shift, 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider answering the EX-stage start/ready handshake.
// Latency: ready_o high 33 cycles after start (2 for divide-by-zero); start_i low aborts, holds END while high.
// Optional DIV_ANNUL_EN adds annul_i, which flushes to FREE from any state.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
`ifdef DIV_ANNUL_EN
    input  logic                annul_i,
`endif
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_remq, w_step;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_neg_q, r_neg_r;
    logic                r_ready, w_ready_nxt;
    logic [2*DATA_W-1:0] r_result, w_result_nxt;
    logic                w_start, w_annul, w_last;
    logic [DATA_W-1:0]   w_mag1, w_mag2, w_q_fix, w_r_fix;

    assign w_start = (start_i == DIV_START);
`ifdef DIV_ANNUL_EN
    assign w_annul = annul_i;
`else
    assign w_annul = 1'b0;
`endif

    assign w_mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

    div_step #(.DATA_W(DATA_W)) u_step (
        .i_remq    (r_remq),
        .i_divisor (r_divisor),
        .o_remq    (w_step)
    );

    // Sign fix-up applied to the final step's output; negating 0x80000000 wraps by design.
    assign w_q_fix = r_neg_q ? -w_step[DATA_W-1:0]        : w_step[DATA_W-1:0];
    assign w_r_fix = r_neg_r ? -w_step[2*DATA_W-1:DATA_W] : w_step[2*DATA_W-1:DATA_W];

    always_comb begin
        w_state_nxt  = r_state;
        w_ready_nxt  = r_ready;
        w_result_nxt = r_result;
        if (w_annul) begin
            w_state_nxt  = DIV_FREE;
            w_ready_nxt  = DIV_RESULT_NOT_READY;
            w_result_nxt = '0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (w_start) begin
                        w_state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    if (!w_start) begin
                        w_state_nxt = DIV_FREE;
                    end else begin
                        w_state_nxt  = DIV_END;
                        w_ready_nxt  = DIV_RESULT_READY;
                        w_result_nxt = '0;
                    end
                end
                DIV_ON: begin
                    if (!w_start) begin
                        w_state_nxt = DIV_FREE;
                    end else if (w_last) begin
                        w_state_nxt  = DIV_END;
                        w_ready_nxt  = DIV_RESULT_READY;
                        w_result_nxt = {w_r_fix, w_q_fix};
                    end
                end
                DIV_END: begin
                    if (!w_start) begin
                        w_state_nxt  = DIV_FREE;
                        w_ready_nxt  = DIV_RESULT_NOT_READY;
                        w_result_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt  = DIV_FREE;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                    w_result_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_ready   <= DIV_RESULT_NOT_READY;
            r_result  <= '0;
            r_cnt     <= '0;
            r_remq    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= w_ready_nxt;
            r_result <= w_result_nxt;
            // Operands are captured only on acceptance; later input changes cannot disturb the op.
            if (r_state == DIV_FREE && w_state_nxt == DIV_ON) begin
                r_remq    <= {{DATA_W{1'b0}}, w_mag1};
                r_divisor <= w_mag2;
                r_neg_q   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                r_neg_r   <= signed_div_i & opdata1_i[DATA_W-1];
                r_cnt     <= '0;
            end else if (r_state == DIV_ON) begin
                r_remq <= w_step;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, divide-by-zero, abort, reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_cmp;
    int n_bad;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
`ifdef DIV_ANNUL_EN
        .annul_i      (annul),
`endif
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold start until ready, count edges from driving start, then release and check the return to idle.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        lat        = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                op1 = $urandom;
                op2 = $urandom;
            end
        end while (!ready && lat < 100);
        check_val({tag, ":lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, ":res"}, result, exp);
        tick();
        check_val({tag, ":hold"}, result, exp);
        start = 1'b0;
        tick();
        check_val({tag, ":rdy_clr"}, {63'd0, ready}, 64'd0);
        check_val({tag, ":res_clr"}, result, 64'd0);
    endtask

    initial begin
        int seen;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        #17;
        check_val("rst:ready", {63'd0, ready}, 64'd0);
        check_val("rst:result", result, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        run_div("u100_7",    1'b0, 32'd100,       32'd7,          {32'd2, 32'd14},                33);
        run_div("s-7_2",     1'b1, 32'hFFFFFFF9,  32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   33);
        run_div("u-7_2",     1'b0, 32'hFFFFFFF9,  32'h2,          {32'd1, 32'h7FFFFFFC},          33);
        run_div("s7_-2",     1'b1, 32'd7,         32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},          33);
        run_div("s-100_-7",  1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},         33);
        run_div("uffff",     1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   {32'd0, 32'd1},                 33);
        run_div("u5_10",     1'b0, 32'd5,         32'd10,         {32'd5, 32'd0},                 33);
        run_div("byzero",    1'b1, 32'h12345678,  32'd0,          64'd0,                          2);
        run_div("ovf",       1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'd0, 32'h80000000},          33);

        // Abort by dropping start after ten steps, then restart immediately.
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        seen       = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (ready) seen = 1;
        end
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ready) seen = 1;
        end
        check_val("abort:no_ready", 64'(seen), 64'd0);
        run_div("restart20_3", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33);

`ifdef DIV_ANNUL_EN
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        seen       = 0;
        repeat (6) tick();
        annul = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready) seen = 1;
        end
        check_val("annul:no_ready", 64'(seen), 64'd0);
        check_val("annul:result", result, 64'd0);
        annul = 1'b0;
        start = 1'b0;
        tick();
        run_div("annul_after", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33);
`endif

        // Asynchronous reset between clock edges while stepping.
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_on:ready", {63'd0, ready}, 64'd0);
        check_val("arst_on:result", result, 64'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_val("arst_on:idle", {63'd0, ready}, 64'd0);

        // Asynchronous reset while a finished result is being held.
        start = 1'b1;
        seen  = 0;
        while (!ready && seen < 100) begin
            tick();
            seen++;
        end
        check_val("arst_end:pre", result, {32'd2, 32'd14});
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_end:ready", {63'd0, ready}, 64'd0);
        check_val("arst_end:result", result, 64'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        run_div("post_rst", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
